// File: rtl/wb_mtimer_pkg.sv
// Shared definitions for the Wishbone RISC-V machine timer: register offsets,
// CTRL word layout and the byte-lane write merge used by every register.
package wb_mtimer_pkg;

  localparam logic [2:0] MTIME_LO_OFS    = 3'd0;
  localparam logic [2:0] MTIME_HI_OFS    = 3'd1;
  localparam logic [2:0] MTIMECMP_LO_OFS = 3'd2;
  localparam logic [2:0] MTIMECMP_HI_OFS = 3'd3;
  localparam logic [2:0] CTRL_OFS        = 3'd4;

  localparam int unsigned CTRL_EN_BIT       = 0;
  localparam int unsigned CTRL_PRESCALE_LSB = 16;
  localparam int unsigned CTRL_PRESCALE_MAX = 16;

  // CTRL as seen on the bus: PRESCALE in [31:16], EN in bit 0, rest reserved.
  typedef struct packed {
    logic [CTRL_PRESCALE_MAX-1:0]                prescale;
    logic [CTRL_PRESCALE_LSB-CTRL_EN_BIT-2:0]    rsvd;
    logic                                        en;
  } ctrl_t;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  sel);
    logic [31:0] res;
    res = old_val;
    for (int unsigned i = 0; i < 4; i++) begin
      if (sel[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/wb_if.sv
// Wishbone B4 pipelined bus bundle, 32-bit data, byte selects.
interface wb_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_m;
  logic [31:0] dat_s;
  logic        ack;
  logic        err;
  logic        stall;

  modport master (output cyc, stb, we, adr, sel, dat_m,
                  input  dat_s, ack, err, stall);
  modport slave  (input  cyc, stb, we, adr, sel, dat_m,
                  output dat_s, ack, err, stall);
endinterface

// File: rtl/wb_mtimer_prescaler.sv
// Prescale counter: counts 0..prescale while enabled and pulses tick on wrap.
module wb_mtimer_prescaler #(
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] cnt_q, cnt_d;

  // A clear takes priority and swallows a coincident wrap tick.
  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == prescale) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + PRESCALE_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/wb_mtimer.sv
// RISC-V machine timer (mtime/mtimecmp + prescaler) as a Wishbone responder;
// drives a registered level irq_timer.
module wb_mtimer
  import wb_mtimer_pkg::*;
#(
  parameter int unsigned PRESCALE_W   = 16,
  parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic  clk,
  input  logic  rst,
  wb_if.slave   wb,
  output logic  irq_timer
);

  logic [63:0]           mtime_q, mtime_d;
  logic [63:0]           mtimecmp_q, mtimecmp_d;
  logic [31:0]           snap_q, snap_d;
  logic [31:0]           dat_s_q, dat_s_d;
  logic                  en_q, en_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic                  irq_q, irq_d;

  logic       req, mapped, wr, rd, ctrl_wr, tick;
  logic [2:0] ofs;
  ctrl_t      ctrl_rd, ctrl_new;
  logic       unused_bits;

  assign req     = wb.cyc & wb.stb;
  assign ofs     = wb.adr[4:2];
  assign mapped  = (ofs <= CTRL_OFS);
  assign wr      = req & mapped & wb.we;
  assign rd      = req & mapped & ~wb.we;
  assign ctrl_wr = wr & (ofs == CTRL_OFS);

  assign unused_bits = ^{wb.adr[31:5], wb.adr[1:0], ctrl_new.rsvd};

  always_comb begin
    ctrl_rd          = '0;
    ctrl_rd.en       = en_q;
    ctrl_rd.prescale = CTRL_PRESCALE_MAX'(prescale_q);
  end

  wb_mtimer_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .en       (en_q),
    .clr      (ctrl_wr),
    .prescale (prescale_q),
    .tick     (tick)
  );

  always_comb begin
    mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d = mtimecmp_q;
    snap_d     = snap_q;
    en_d       = en_q;
    prescale_d = prescale_q;
    ctrl_new   = ctrl_t'(merge_lanes(ctrl_rd, wb.dat_m, wb.sel));
    ack_d      = req & mapped;
    err_d      = req & ~mapped;
    dat_s_d    = '0;

    // Bus writes to mtime replace the whole next value, so a same-cycle tick is lost.
    if (wr) begin
      case (ofs)
        MTIME_LO_OFS:    mtime_d    = {mtime_q[63:32], merge_lanes(mtime_q[31:0], wb.dat_m, wb.sel)};
        MTIME_HI_OFS:    mtime_d    = {merge_lanes(mtime_q[63:32], wb.dat_m, wb.sel), mtime_q[31:0]};
        MTIMECMP_LO_OFS: mtimecmp_d = {mtimecmp_q[63:32], merge_lanes(mtimecmp_q[31:0], wb.dat_m, wb.sel)};
        MTIMECMP_HI_OFS: mtimecmp_d = {merge_lanes(mtimecmp_q[63:32], wb.dat_m, wb.sel), mtimecmp_q[31:0]};
        CTRL_OFS: begin
          en_d       = ctrl_new.en;
          prescale_d = PRESCALE_W'(ctrl_new.prescale);
        end
        default: ;
      endcase
    end

    // Reading LO latches the live upper half so a following HI read is coherent.
    if (rd) begin
      case (ofs)
        MTIME_LO_OFS: begin
          dat_s_d = mtime_q[31:0];
          snap_d  = mtime_q[63:32];
        end
        MTIME_HI_OFS:    dat_s_d = snap_q;
        MTIMECMP_LO_OFS: dat_s_d = mtimecmp_q[31:0];
        MTIMECMP_HI_OFS: dat_s_d = mtimecmp_q[63:32];
        CTRL_OFS:        dat_s_d = ctrl_rd;
        default: ;
      endcase
    end

    irq_d = (mtime_d >= mtimecmp_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_q    <= '0;
      mtimecmp_q <= MTIMECMP_RST;
      snap_q     <= '0;
      dat_s_q    <= '0;
      en_q       <= 1'b1;
      prescale_q <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      snap_q     <= snap_d;
      dat_s_q    <= dat_s_d;
      en_q       <= en_d;
      prescale_q <= prescale_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      irq_q      <= irq_d;
    end
  end

  // A response pending while rst is high belongs to a dropped request.
  assign wb.ack   = ack_q & ~rst;
  assign wb.err   = err_q & ~rst;
  assign wb.dat_s = dat_s_q;
  assign wb.stall = 1'b0;
  assign irq_timer = irq_q;

endmodule
